// File: rtl/pipe_rr_sched_if.sv
// Requester/downstream bundle for pipe_rr_sched.
// The master side drives requests and out_ready; the slave side is the scheduler.
interface pipe_rr_sched_if #(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
);
    logic [N-1:0]   req;
    logic [N*W-1:0] data_in;
    logic [N-1:0]   grant;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [IDW-1:0] out_id;
    logic           out_ready;
    logic           busy;

    modport master (
        output req, data_in, out_ready,
        input  grant, out_valid, out_data, out_id, busy
    );

    modport slave (
        input  req, data_in, out_ready,
        output grant, out_valid, out_data, out_id, busy
    );
endinterface

// File: rtl/pipe_rr_sched.sv
// Round-robin scheduler with bounded burst lock feeding a shared
// DEPTH-stage registered pipeline; backpressure freezes the whole chain.
module pipe_rr_sched #(
    parameter int N         = 4,
    parameter int W         = 8,
    parameter int DEPTH     = 2,
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           rst,
    pipe_rr_sched_if.slave bus
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;
    localparam int CW  = $clog2(MAX_BURST + 1);

    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_owner;
    logic             r_own_vld;
    logic [CW-1:0]    r_cnt;
    logic [DEPTH-1:0] r_v;
    logic [W-1:0]     r_data [DEPTH];
    logic [IDW-1:0]   r_id   [DEPTH];

    logic             w_adv;
    logic             w_cont;
    logic             w_hit;
    logic             w_go;
    logic             w_new;
    logic [IDW-1:0]   w_win;
    logic [IDW-1:0]   w_ptr_nxt;
    logic [N-1:0]     w_grant;

    assign w_adv  = ~(r_v[DEPTH-1] & ~bus.out_ready);
    assign w_cont = r_own_vld & bus.req[r_owner]
                  & (r_cnt < CW'(MAX_BURST));

    // Scan runs from the far end so the offset closest to ptr wins last.
    always_comb begin
        int j;
        j       = 0;
        w_hit   = 1'b0;
        w_win   = r_owner;
        w_grant = '0;
        if (w_cont) begin
            w_hit = 1'b1;
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                j = int'(r_ptr) + i;
                if (j >= N) j = j - N;
                if (bus.req[j]) begin
                    w_hit = 1'b1;
                    w_win = IDW'(j);
                end
            end
        end
        if (w_hit && w_adv && !rst) w_grant[w_win] = 1'b1;
    end

    assign w_go      = |w_grant;
    assign w_new     = ~r_own_vld | (w_win != r_owner)
                     | (r_cnt == CW'(MAX_BURST));
    assign w_ptr_nxt = (w_win == IDW'(N - 1)) ? '0 : w_win + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr     <= '0;
            r_owner   <= '0;
            r_own_vld <= 1'b0;
            r_cnt     <= '0;
        end else if (w_adv) begin
            if (w_go) begin
                r_owner   <= w_win;
                r_own_vld <= 1'b1;
                r_ptr     <= w_ptr_nxt;
                r_cnt     <= w_new ? CW'(1) : r_cnt + 1'b1;
            end else begin
                r_own_vld <= 1'b0;
                r_cnt     <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_id[i]   <= '0;
            end
        end else if (w_adv) begin
            r_v[0] <= w_go;
            if (w_go) begin
                r_data[0] <= bus.data_in[int'(w_win) * W +: W];
                r_id[0]   <= w_win;
            end
            for (int i = 1; i < DEPTH; i++) begin
                r_v[i]    <= r_v[i-1];
                r_data[i] <= r_data[i-1];
                r_id[i]   <= r_id[i-1];
            end
        end
    end

    assign bus.grant     = w_grant;
    assign bus.out_valid = r_v[DEPTH-1];
    assign bus.out_data  = r_data[DEPTH-1];
    assign bus.out_id    = r_id[DEPTH-1];
    assign bus.busy      = |r_v;
endmodule
